spdif_encoder: RTL and testbench

//  S/PDIF (IEC 60958 consumer) transmitter; the transmit end of the link that spdif_decoder receives.

---
 rtl/spdif_encoder_pkg.sv | 24 ++
 rtl/spdif_encoder_bmc_out.sv | 47 ++++
 rtl/spdif_encoder.sv | 153 +++++++++++++++
 tb/tb_spdif_encoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_encoder_pkg.sv
// Shared S/PDIF line constants: preamble patterns, frame geometry, slot map.
package spdif_encoder_pkg;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    localparam int HC_PER_FRAME     = 128;
    localparam int FRAMES_PER_BLOCK = 192;

    localparam logic [4:0] SLOT_PRE_LAST  = 5'd3;
    localparam logic [4:0] SLOT_AUD_FIRST = 5'd4;
    localparam logic [4:0] SLOT_AUD_LAST  = 5'd27;
    localparam logic [4:0] SLOT_V         = 5'd28;
    localparam logic [4:0] SLOT_U         = 5'd29;
    localparam logic [4:0] SLOT_C         = 5'd30;
    localparam logic [4:0] SLOT_P         = 5'd31;

    // Channel-status bit for a frame: only the first 32 frames of a block carry the word.
    function automatic logic cs_bit(input logic [31:0] word, input logic [7:0] frm);
        return (frm < 8'd32) ? word[frm[4:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/spdif_encoder_bmc_out.sv
// Biphase-mark line driver: owns the line-level register that is tx_out.
module spdif_bmc_out
    import spdif_encoder_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_tick,
    input  logic i_half,
    input  logic i_data,
    input  logic i_is_pre,
    input  logic i_pre_first,
    input  logic i_pre_bit,
    output logic o_tx
);

    logic r_level;
    logic r_pre_base;

    // Preamble half-cells are XORed with the level seen just before the preamble;
    // data cells toggle at cell start and again mid-cell for a 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level    <= 1'b0;
            r_pre_base <= 1'b0;
        end else if (i_clr) begin
            r_level    <= 1'b0;
            r_pre_base <= 1'b0;
        end else if (i_tick) begin
            if (i_is_pre) begin
                if (i_pre_first) begin
                    r_pre_base <= r_level;
                    r_level    <= i_pre_bit ^ r_level;
                end else begin
                    r_level <= i_pre_bit ^ r_pre_base;
                end
            end else if (!i_half) begin
                r_level <= ~r_level;
            end else begin
                r_level <= r_level ^ i_data;
            end
        end
    end

    assign o_tx = r_level;

endmodule

// File: rtl/spdif_encoder.sv
// S/PDIF consumer transmitter: divider, half-cell/frame counters, one-entry
// sample buffer, subframe mux and V/U/C/P generation feeding the BMC driver.
module spdif_encoder
    import spdif_encoder_pkg::*;
#(
    parameter int          CLK_DIV = 4,
    parameter logic [31:0] CS_WORD = 32'h0000_0004
) (
    input  logic        clk_in,
    input  logic        resetb,
    input  logic        ena,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        tx_out,
    output logic        frame_start,
    output logic        underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_hc;
    logic [7:0]       r_frm;
    logic             r_buf_full;
    logic [23:0]      r_buf_l;
    logic [23:0]      r_buf_r;
    logic [23:0]      r_frame_l;
    logic [23:0]      r_frame_r;
    logic             r_frame_v;

    logic        w_tick;
    logic        w_load;
    logic        w_accept;
    logic        w_right;
    logic [4:0]  w_slot;
    logic        w_half;
    logic [4:0]  w_aud_idx;
    logic [2:0]  w_pre_idx;
    logic [23:0] w_sample;
    logic        w_c;
    logic        w_parity;
    logic        w_is_pre;
    logic        w_pre_first;
    logic [7:0]  w_pattern;
    logic        w_pre_bit;
    logic        w_data_bit;

    // r_hc is the half-cell emitted on the next tick, so hc==0 at a tick is the frame load.
    assign w_tick   = ena && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_load   = w_tick && (r_hc == 7'd0);
    assign w_accept = sample_valid && !r_buf_full;

    assign sample_ready = !r_buf_full;
    assign frame_start  = w_load;
    assign underrun     = w_load && !r_buf_full;

    // Divider and half-cell/frame counters; ena low parks everything at block start.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_div <= '0;
            r_hc  <= '0;
            r_frm <= '0;
        end else if (!ena) begin
            r_div <= '0;
            r_hc  <= '0;
            r_frm <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_hc  <= r_hc + 7'd1;
            if (r_hc == 7'(HC_PER_FRAME - 1)) begin
                r_frm <= (r_frm == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frm + 8'd1;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // One-entry holding buffer; a frame load empties it, an accept fills it.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else begin
            if (w_load) begin
                r_buf_full <= 1'b0;
            end
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_l    <= sample_l;
                r_buf_r    <= sample_r;
            end
        end
    end

    // Frame registers: buffered sample, or silence flagged invalid on underrun.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_frame_l <= '0;
            r_frame_r <= '0;
            r_frame_v <= 1'b0;
        end else if (w_load) begin
            r_frame_l <= r_buf_full ? r_buf_l : 24'd0;
            r_frame_r <= r_buf_full ? r_buf_r : 24'd0;
            r_frame_v <= !r_buf_full;
        end
    end

    assign w_right     = r_hc[6];
    assign w_slot      = r_hc[5:1];
    assign w_half      = r_hc[0];
    assign w_aud_idx   = w_slot - SLOT_AUD_FIRST;
    assign w_pre_idx   = {w_slot[1:0], w_half};
    assign w_sample    = w_right ? r_frame_r : r_frame_l;
    assign w_c         = cs_bit(CS_WORD, r_frm);
    assign w_parity    = ^{w_sample, r_frame_v, 1'b0, w_c};
    assign w_is_pre    = (w_slot <= SLOT_PRE_LAST);
    assign w_pre_first = (r_hc[5:0] == 6'd0);
    assign w_pattern   = w_right ? PRE_W : ((r_frm == 8'd0) ? PRE_B : PRE_M);
    assign w_pre_bit   = w_pattern[3'd7 - w_pre_idx];

    // Slot mux for the data bit of the half-cell about to be sent.
    always_comb begin
        w_data_bit = 1'b0;
        if (w_slot == SLOT_V) begin
            w_data_bit = r_frame_v;
        end else if (w_slot == SLOT_U) begin
            w_data_bit = 1'b0;
        end else if (w_slot == SLOT_C) begin
            w_data_bit = w_c;
        end else if (w_slot == SLOT_P) begin
            w_data_bit = w_parity;
        end else if (w_slot >= SLOT_AUD_FIRST && w_slot <= SLOT_AUD_LAST) begin
            w_data_bit = w_sample[w_aud_idx];
        end
    end

    spdif_bmc_out u_bmc (
        .i_clk       (clk_in),
        .i_rst_n     (resetb),
        .i_clr       (!ena),
        .i_tick      (w_tick),
        .i_half      (w_half),
        .i_data      (w_data_bit),
        .i_is_pre    (w_is_pre),
        .i_pre_first (w_pre_first),
        .i_pre_bit   (w_pre_bit),
        .o_tx        (tx_out)
    );

endmodule

// File: tb/tb_spdif_encoder.sv
// Scoreboard bench: accepted samples are queued, each transmitted frame is
// captured from tx_out, BMC-decoded and compared with the queue head.
module tb_spdif_encoder;

    localparam int          DIV    = 2;
    localparam logic [31:0] CSW    = 32'h0000_0004;
    localparam int          HC_CYC = 128 * DIV;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        resetb;
    logic        ena;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        tx_out;
    logic        frame_start;
    logic        underrun;

    spdif_encoder #(.CLK_DIV(DIV), .CS_WORD(CSW)) dut (
        .clk_in       (clk_in),
        .resetb       (resetb),
        .ena          (ena),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .tx_out       (tx_out),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    exp_t         sb[$];
    exp_t         cur;
    logic [31:0]  csw_v = CSW;
    logic [31:0]  cs_seen = '0;
    logic [127:0] h;
    logic         capturing = 1'b0;
    logic         hold_err;
    logic         base_lvl;
    int           cnt;
    int           fs_count = 0;
    int           frm_model = 0;
    int           cur_frm;
    int           b_count = 0;
    int           underrun_count = 0;
    int           acc_in_frame = 0;

    task automatic decode_frame();
        logic [31:0] bits;
        logic [7:0]  pat;
        logic [7:0]  pexp;
        logic        base;
        logic        prev;
        logic        a;
        logic        b;
        int          off;
        int          bmc_err;
        for (int s = 0; s < 2; s++) begin
            off  = s * 64;
            base = (s == 0) ? base_lvl : h[63];
            for (int i = 0; i < 8; i++) pat[7-i] = h[off+i] ^ base;
            pexp = (s == 1) ? 8'b11100100 : ((cur_frm == 0) ? 8'b11101000 : 8'b11100010);
            chk((s == 0) ? "preamble_L" : "preamble_R", 32'(pat), 32'(pexp));
            if (s == 0 && pat == 8'b11101000) b_count++;
            bits    = '0;
            bmc_err = 0;
            prev    = h[off+7];
            for (int k = 4; k < 32; k++) begin
                a = h[off+2*k];
                b = h[off+2*k+1];
                if (a == prev) bmc_err++;
                bits[k] = a ^ b;
                prev    = b;
            end
            chk("bmc_cell_edge", bmc_err, 0);
            chk((s == 0) ? "audio_L" : "audio_R", 32'(bits[27:4]), 32'((s == 0) ? cur.l : cur.r));
            chk("v_bit", 32'(bits[28]), 32'(cur.v));
            chk("u_bit", 32'(bits[29]), 0);
            chk("c_bit", 32'(bits[30]), (cur_frm < 32) ? 32'(csw_v[cur_frm]) : 0);
            chk("parity_even", 32'(^bits[31:4]), 0);
            chk("subframe_end_level", 32'(h[off+63]), 32'(base));
            if (s == 0 && cur_frm < 32) cs_seen[cur_frm] = bits[30];
        end
        chk("halfcell_hold", 32'(hold_err), 0);
        if (cur_frm == 31) chk("cs_word", cs_seen, csw_v);
    endtask

    // Monitor: captures frames, checks handshake timing, keeps the scoreboard.
    initial begin : monitor
        logic prev_ena;
        logic prev_accept;
        logic prev_fs;
        logic prev_ready;
        prev_ena = 1'b1; prev_accept = 1'b0; prev_fs = 1'b0; prev_ready = 1'b1;
        @(posedge resetb);
        forever begin
            @(negedge clk_in);
            if (capturing) begin
                if (cnt % DIV == 0) h[cnt/DIV] = tx_out;
                else if (tx_out !== h[cnt/DIV]) hold_err = 1'b1;
                cnt++;
                if (cnt == HC_CYC) begin
                    capturing = 1'b0;
                    decode_frame();
                end
            end
            if (!prev_ena) chk("tx_idle", 32'(tx_out), 0);
            if (!ena) begin
                chk("fs_idle", 32'(frame_start), 0);
                capturing = 1'b0;
                frm_model = 0;
            end
            if (prev_accept) chk("ready_drop", 32'(sample_ready), 0);
            if (prev_fs && !prev_ready) chk("ready_rise", 32'(sample_ready), 1);
            if (frame_start) begin
                if (fs_count > 0) chk("one_xfer_per_frame", 32'(acc_in_frame <= 1), 1);
                acc_in_frame = 0;
                fs_count++;
                chk("underrun_flag", 32'(underrun), 32'(sb.size() == 0));
                if (underrun) underrun_count++;
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                end else begin
                    cur.l = '0; cur.r = '0; cur.v = 1'b1;
                end
                cur_frm   = frm_model;
                frm_model = (frm_model + 1) % 192;
                base_lvl  = tx_out;
                capturing = 1'b1;
                cnt       = 0;
                hold_err  = 1'b0;
            end else if (underrun) begin
                chk("underrun_stray", 32'(underrun), 0);
            end
            prev_accept = sample_valid && sample_ready;
            if (prev_accept) begin
                sb.push_back({sample_l, sample_r, 1'b0});
                acc_in_frame++;
            end
            prev_ena   = ena;
            prev_fs    = frame_start;
            prev_ready = sample_ready;
        end
    end

    // Source: fixed pattern for the first frames, random after; starves frame 5.
    initial begin : driver
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        @(posedge resetb);
        for (int n = 0; n < 400; n++) begin
            if (n == 5) begin
                sample_valid = 1'b0;
                for (int t = 0; t < 4 * HC_CYC && fs_count < 6; t++) @(posedge clk_in);
                #1;
            end
            if (n < 3) begin
                sample_l = 24'h000001;
                sample_r = 24'h800000;
            end else begin
                sample_l = 24'($urandom);
                sample_r = 24'($urandom);
            end
            sample_valid = 1'b1;
            for (int t = 0; t < 4 * HC_CYC; t++) begin
                @(negedge clk_in);
                if (sample_ready) break;
            end
            @(posedge clk_in);
            #1;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int t;
        resetb = 1'b0;
        ena    = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_tx_out", 32'(tx_out), 0);
        chk("rst_ready", 32'(sample_ready), 1);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_underrun", 32'(underrun), 0);
        @(posedge clk_in);
        #1;
        resetb = 1'b1;
        ena    = 1'b1;

        for (t = 0; t < 220 * HC_CYC && fs_count < 196; t++) @(posedge clk_in);
        chk("frames_before_drop", fs_count, 196);

        repeat (70 * DIV) @(posedge clk_in);
        #1 ena = 1'b0;
        repeat (10) @(posedge clk_in);
        #1 ena = 1'b1;
        t = 0;
        do begin
            @(negedge clk_in);
            t++;
        end while (!frame_start && t < 50);
        chk("restart_latency", t, DIV);

        for (t = 0; t < 6 * HC_CYC && fs_count < 200; t++) @(posedge clk_in);
        repeat (HC_CYC + 4) @(posedge clk_in);

        chk("underrun_total", underrun_count, 1);
        chk("b_preamble_total", b_count, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
